// File: rtl/decode_stage.sv
// RV32I decode pipeline stage: decodes the incoming instruction combinationally and
// registers the bundle behind a valid/ready handshake with a one-entry skid buffer.
module decode_stage #(
    parameter int PC_W      = 32,
    parameter int SUPPORT_M = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [31:0]     out_imm,
    output logic [4:0]      out_alu_ctr,
    output logic            out_alu_b_sel,
    output logic [3:0]      out_bxx,
    output logic            out_jal,
    output logic            out_jalr,
    output logic            out_reg_we,
    output logic            out_mem_we,
    output logic [2:0]      out_mem2reg,
    output logic [2:0]      out_mem_opr,
    output logic [3:0]      out_mem_opw,
    output logic            out_illegal
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    localparam logic M_EN = (SUPPORT_M != 0);

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [31:0]     imm;
        logic [4:0]      alu_ctr;
        logic            alu_b_sel;
        logic [3:0]      bxx;
        logic            jal;
        logic            jalr;
        logic            reg_we;
        logic            mem_we;
        logic [2:0]      mem2reg;
        logic [2:0]      mem_opr;
        logic [3:0]      mem_opw;
        logic            illegal;
    } bundle_t;

    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    logic is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store, is_opimm, is_op;
    logic op_legal;
    logic illegal;
    bundle_t dec;

    assign opcode = in_instr[6:0];
    assign func3  = in_instr[14:12];
    assign func7  = in_instr[31:25];

    assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u = {in_instr[31:12], 12'h000};
    assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

    assign is_lui    = (opcode == OPC_LUI);
    assign is_auipc  = (opcode == OPC_AUIPC);
    assign is_jal    = (opcode == OPC_JAL);
    assign is_jalr   = (opcode == OPC_JALR);
    assign is_branch = (opcode == OPC_BRANCH);
    assign is_load   = (opcode == OPC_LOAD);
    assign is_store  = (opcode == OPC_STORE);
    assign is_opimm  = (opcode == OPC_OPIMM);
    assign is_op     = (opcode == OPC_OP);

    always_comb begin
        op_legal = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL: op_legal = 1'b1;
            OPC_JALR:   op_legal = (func3 == 3'b000);
            OPC_BRANCH: op_legal = (func3[2:1] != 2'b01);
            OPC_LOAD:   op_legal = (func3 != 3'b011) && (func3[2:1] != 2'b11);
            OPC_STORE:  op_legal = (func3 < 3'b011);
            // only the shift-immediates carry a func7 field; other I-ALU ops use those bits as immediate
            OPC_OPIMM: begin
                if (func3 == 3'b001)
                    op_legal = (func7 == F7_BASE);
                else if (func3 == 3'b101)
                    op_legal = (func7 == F7_BASE) || (func7 == F7_ALT);
                else
                    op_legal = 1'b1;
            end
            OPC_OP: op_legal = (func7 == F7_BASE)
                            || ((func7 == F7_ALT) && ((func3 == 3'b000) || (func3 == 3'b101)))
                            || ((func7 == F7_MUL) && M_EN);
            default: op_legal = 1'b0;
        endcase
        illegal = !op_legal || (in_instr[1:0] != 2'b11);
    end

    always_comb begin
        dec         = '0;
        dec.pc      = in_pc;
        dec.rs1     = in_instr[19:15];
        dec.rs2     = in_instr[24:20];
        dec.rd      = in_instr[11:7];
        dec.bxx     = {is_branch && !illegal, func3};
        dec.illegal = illegal;
        if (!illegal) begin
            if (is_branch)
                dec.imm = imm_b;
            else if (is_store)
                dec.imm = imm_s;
            else if (is_lui || is_auipc)
                dec.imm = imm_u;
            else if (is_jal)
                dec.imm = imm_j;
            else if (!is_op)
                dec.imm = imm_i;

            // branches compare via sub (eq/ne), slt (lt/ge) or sltu (ltu/geu)
            if (is_op)
                dec.alu_ctr = (func7 == F7_MUL) ? {2'b10, func3} : {1'b0, func7[5], func3};
            else if (is_opimm)
                dec.alu_ctr = {1'b0, (func3 == 3'b101) && func7[5], func3};
            else if (is_branch)
                dec.alu_ctr = func3[2] ? {4'b0001, func3[1]} : 5'b01000;

            dec.alu_b_sel = !(is_op || is_branch);
            dec.jal       = is_jal;
            dec.jalr      = is_jalr;
            dec.reg_we    = !(is_branch || is_store) && (in_instr[11:7] != 5'd0);
            dec.mem_we    = is_store;
            dec.mem_opr   = is_load ? func3 : 3'b000;

            if (is_load)
                dec.mem2reg = 3'b001;
            else if (is_jal || is_jalr)
                dec.mem2reg = 3'b010;
            else if (is_lui)
                dec.mem2reg = 3'b011;
            else if (is_auipc)
                dec.mem2reg = 3'b100;

            if (is_store)
                dec.mem_opw = (func3 == 3'b000) ? 4'b0001 : (func3 == 3'b001) ? 4'b0011 : 4'b1111;
        end
    end

    logic    out_valid_q, out_valid_d;
    logic    skid_valid_q, skid_valid_d;
    bundle_t main_q, main_d;
    bundle_t skid_q, skid_d;
    logic    accept;
    logic    load_main;

    assign in_ready  = rst_n && !skid_valid_q;
    assign accept    = in_valid && in_ready;
    assign load_main = !out_valid_q || out_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        main_d       = main_q;
        skid_d       = skid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (load_main) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d      = dec;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            main_q       <= '0;
            skid_q       <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_pc        = main_q.pc;
    assign out_rs1       = main_q.rs1;
    assign out_rs2       = main_q.rs2;
    assign out_rd        = main_q.rd;
    assign out_imm       = main_q.imm;
    assign out_alu_ctr   = main_q.alu_ctr;
    assign out_alu_b_sel = main_q.alu_b_sel;
    assign out_bxx       = main_q.bxx;
    assign out_jal       = main_q.jal;
    assign out_jalr      = main_q.jalr;
    assign out_reg_we    = main_q.reg_we;
    assign out_mem_we    = main_q.mem_we;
    assign out_mem2reg   = main_q.mem2reg;
    assign out_mem_opr   = main_q.mem_opr;
    assign out_mem_opw   = main_q.mem_opw;
    assign out_illegal   = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: two instances (M-extension off/on) share stimulus and are compared
// every cycle against a two-entry queue model that decodes from the RV32I rules.
module tb_decode_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [4:0]  alu_ctr;
        logic        alu_b_sel;
        logic [3:0]  bxx;
        logic        jal;
        logic        jalr;
        logic        reg_we;
        logic        mem_we;
        logic [2:0]  mem2reg;
        logic [2:0]  mem_opr;
        logic [3:0]  mem_opw;
        logic        illegal;
    } bundle_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } item_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_ready;

    logic in_ready0, in_ready1, out_valid0, out_valid1;
    bundle_t obs0, obs1;

    int checks = 0;
    int errors = 0;
    item_t q[$];

    always #5 clk = ~clk;

    decode_stage #(.PC_W(32), .SUPPORT_M(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready0), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid0), .out_ready(out_ready), .out_pc(obs0.pc),
        .out_rs1(obs0.rs1), .out_rs2(obs0.rs2), .out_rd(obs0.rd), .out_imm(obs0.imm),
        .out_alu_ctr(obs0.alu_ctr), .out_alu_b_sel(obs0.alu_b_sel), .out_bxx(obs0.bxx),
        .out_jal(obs0.jal), .out_jalr(obs0.jalr), .out_reg_we(obs0.reg_we),
        .out_mem_we(obs0.mem_we), .out_mem2reg(obs0.mem2reg), .out_mem_opr(obs0.mem_opr),
        .out_mem_opw(obs0.mem_opw), .out_illegal(obs0.illegal)
    );

    decode_stage #(.PC_W(32), .SUPPORT_M(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid1), .out_ready(out_ready), .out_pc(obs1.pc),
        .out_rs1(obs1.rs1), .out_rs2(obs1.rs2), .out_rd(obs1.rd), .out_imm(obs1.imm),
        .out_alu_ctr(obs1.alu_ctr), .out_alu_b_sel(obs1.alu_b_sel), .out_bxx(obs1.bxx),
        .out_jal(obs1.jal), .out_jalr(obs1.jalr), .out_reg_we(obs1.reg_we),
        .out_mem_we(obs1.mem_we), .out_mem2reg(obs1.mem2reg), .out_mem_opr(obs1.mem_opr),
        .out_mem_opw(obs1.mem_opw), .out_illegal(obs1.illegal)
    );

    // Reference decoder written straight from the instruction-set rules.
    function automatic bundle_t modelDecode(input logic [31:0] w, input logic [31:0] pc, input bit mExt);
        bundle_t e;
        logic [6:0] op;
        logic [6:0] f7;
        logic [2:0] f3;
        bit ok;
        bit writes;
        e = '0;
        op = w[6:0];
        f3 = w[14:12];
        f7 = w[31:25];
        e.pc = pc;
        e.rs1 = w[19:15];
        e.rs2 = w[24:20];
        e.rd = w[11:7];
        e.bxx[2:0] = f3;
        e.alu_b_sel = 1'b1;
        ok = 1'b1;
        writes = 1'b1;
        case (op)
            7'b0110111: begin e.imm = {w[31:12], 12'h000}; e.mem2reg = 3'd3; end
            7'b0010111: begin e.imm = {w[31:12], 12'h000}; e.mem2reg = 3'd4; end
            7'b1101111: begin
                e.imm = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
                e.jal = 1'b1; e.mem2reg = 3'd2;
            end
            7'b1100111: begin
                ok = (f3 == 3'd0);
                e.imm = 32'($signed(w[31:20]));
                e.jalr = 1'b1; e.mem2reg = 3'd2;
            end
            7'b1100011: begin
                ok = !(f3 == 3'd2 || f3 == 3'd3);
                e.imm = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
                e.bxx[3] = 1'b1; e.alu_b_sel = 1'b0; writes = 1'b0;
                e.alu_ctr = (f3 < 3'd2) ? 5'b01000 : (f3 < 3'd6) ? 5'b00010 : 5'b00011;
            end
            7'b0000011: begin
                ok = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
                e.imm = 32'($signed(w[31:20]));
                e.mem2reg = 3'd1; e.mem_opr = f3;
            end
            7'b0100011: begin
                ok = (f3 < 3'd3);
                e.imm = 32'($signed({w[31:25], w[11:7]}));
                e.mem_we = 1'b1; writes = 1'b0;
                e.mem_opw = (f3 == 3'd0) ? 4'h1 : (f3 == 3'd1) ? 4'h3 : 4'hF;
            end
            7'b0010011: begin
                e.imm = 32'($signed(w[31:20]));
                if (f3 == 3'd1) ok = (f7 == 7'h00);
                else if (f3 == 3'd5) ok = (f7 == 7'h00 || f7 == 7'h20);
                e.alu_ctr = (f3 == 3'd5 && f7 == 7'h20) ? 5'b01101 : {2'b00, f3};
            end
            7'b0110011: begin
                e.alu_b_sel = 1'b0;
                if (f7 == 7'h00) e.alu_ctr = {2'b00, f3};
                else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) e.alu_ctr = {2'b01, f3};
                else if (f7 == 7'h01 && mExt) e.alu_ctr = {2'b10, f3};
                else ok = 1'b0;
            end
            default: ok = 1'b0;
        endcase
        if (w[1:0] != 2'b11) ok = 1'b0;
        e.illegal = !ok;
        e.reg_we = ok && writes && (e.rd != 5'd0);
        if (!ok) begin
            e.imm = '0; e.mem_we = 1'b0; e.jal = 1'b0; e.jalr = 1'b0; e.bxx[3] = 1'b0;
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkBundle(input string tag, input bundle_t a, input bundle_t e);
        chk({tag, ".pc"}, a.pc, e.pc);
        chk({tag, ".rs1"}, 32'(a.rs1), 32'(e.rs1));
        chk({tag, ".rs2"}, 32'(a.rs2), 32'(e.rs2));
        chk({tag, ".rd"}, 32'(a.rd), 32'(e.rd));
        chk({tag, ".imm"}, a.imm, e.imm);
        chk({tag, ".bxx"}, 32'(a.bxx), 32'(e.bxx));
        chk({tag, ".jal"}, 32'(a.jal), 32'(e.jal));
        chk({tag, ".jalr"}, 32'(a.jalr), 32'(e.jalr));
        chk({tag, ".reg_we"}, 32'(a.reg_we), 32'(e.reg_we));
        chk({tag, ".mem_we"}, 32'(a.mem_we), 32'(e.mem_we));
        chk({tag, ".illegal"}, 32'(a.illegal), 32'(e.illegal));
        if (!e.illegal) begin
            chk({tag, ".alu_ctr"}, 32'(a.alu_ctr), 32'(e.alu_ctr));
            chk({tag, ".alu_b_sel"}, 32'(a.alu_b_sel), 32'(e.alu_b_sel));
            chk({tag, ".mem2reg"}, 32'(a.mem2reg), 32'(e.mem2reg));
            chk({tag, ".mem_opr"}, 32'(a.mem_opr), 32'(e.mem_opr));
            chk({tag, ".mem_opw"}, 32'(a.mem_opw), 32'(e.mem_opw));
        end
    endtask

    // Model: the stage behaves as a two-deep FIFO whose head is presented downstream.
    always @(posedge clk or negedge rst_n) begin
        int n;
        if (!rst_n) begin
            q.delete();
        end else if (flush) begin
            q.delete();
        end else begin
            n = q.size();
            if (n > 0 && out_ready) void'(q.pop_front());
            if (in_valid && n < 2) q.push_back('{instr: in_instr, pc: in_pc});
        end
    end

    task automatic checkOutput();
        int n;
        bundle_t e;
        n = q.size();
        chk("dut0.in_ready", 32'(in_ready0), 32'(rst_n === 1'b1 && n < 2));
        chk("dut1.in_ready", 32'(in_ready1), 32'(rst_n === 1'b1 && n < 2));
        chk("dut0.out_valid", 32'(out_valid0), 32'(n > 0));
        chk("dut1.out_valid", 32'(out_valid1), 32'(n > 0));
        if (rst_n !== 1'b1) begin
            chkBundle("dut0.rst", obs0, '0);
            chkBundle("dut1.rst", obs1, '0);
        end else if (n > 0) begin
            e = modelDecode(q[0].instr, q[0].pc, 1'b0);
            chkBundle("dut0", obs0, e);
            e = modelDecode(q[0].instr, q[0].pc, 1'b1);
            chkBundle("dut1", obs1, e);
        end
    endtask

    always @(negedge clk) checkOutput();

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc = pc;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    function automatic logic [31:0] randInstr();
        logic [31:0] w;
        int r;
        w = $urandom();
        r = $urandom_range(0, 9);
        case (r)
            0: w[6:0] = 7'b0110111;
            1: w[6:0] = 7'b0010111;
            2: w[6:0] = 7'b1101111;
            3: w[6:0] = 7'b1100111;
            4: w[6:0] = 7'b1100011;
            5: w[6:0] = 7'b0000011;
            6: w[6:0] = 7'b0100011;
            7: w[6:0] = 7'b0010011;
            8: w[6:0] = 7'b0110011;
            default: ;
        endcase
        if (r != 9) begin
            case ($urandom_range(0, 4))
                0: w[31:25] = 7'h00;
                1: w[31:25] = 7'h20;
                2: w[31:25] = 7'h01;
                default: ;
            endcase
        end
        return w;
    endfunction

    initial begin
        bundle_t m;
        rst_n = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        in_instr = '0;
        in_pc = '0;
        out_ready = 1'b1;

        #2;
        chk("reset.out_valid", 32'(out_valid0), 32'h0);
        chk("reset.in_ready", 32'(in_ready0), 32'h0);
        chk("reset.imm", obs0.imm, 32'h0);
        #10;
        rst_n = 1'b1;
        tick();

        m = modelDecode(32'hFE209EE3, 32'h0, 1'b0);
        chk("model.bne_imm", m.imm, 32'hFFFF_FFFC);
        m = modelDecode(32'h022082B3, 32'h0, 1'b1);
        chk("model.mul_alu", 32'(m.alu_ctr), 32'h10);

        applyStimulus(32'h00500093, 32'h0000_1000);
        chk("addi.out_valid", 32'(out_valid0), 32'h1);
        chk("addi.imm", obs0.imm, 32'h5);
        chk("addi.alu_ctr", 32'(obs0.alu_ctr), 32'h0);
        chk("addi.alu_b_sel", 32'(obs0.alu_b_sel), 32'h1);
        chk("addi.rd", 32'(obs0.rd), 32'h1);
        chk("addi.reg_we", 32'(obs0.reg_we), 32'h1);
        chk("addi.mem2reg", 32'(obs0.mem2reg), 32'h0);
        chk("addi.pc", obs0.pc, 32'h0000_1000);

        applyStimulus(32'h402081B3, 32'h0000_1004);
        chk("sub.alu_ctr", 32'(obs0.alu_ctr), 32'h08);
        chk("sub.alu_b_sel", 32'(obs0.alu_b_sel), 32'h0);

        applyStimulus(32'hFE209EE3, 32'h0000_1008);
        chk("bne.imm", obs0.imm, 32'hFFFF_FFFC);
        chk("bne.bxx", 32'(obs0.bxx), 32'h9);
        chk("bne.alu_ctr", 32'(obs0.alu_ctr), 32'h08);
        chk("bne.reg_we", 32'(obs0.reg_we), 32'h0);

        applyStimulus(32'h022082B3, 32'h0000_100C);
        chk("mul.m1.alu_ctr", 32'(obs1.alu_ctr), 32'h10);
        chk("mul.m1.illegal", 32'(obs1.illegal), 32'h0);
        chk("mul.m1.reg_we", 32'(obs1.reg_we), 32'h1);
        chk("mul.m0.illegal", 32'(obs0.illegal), 32'h1);
        chk("mul.m0.reg_we", 32'(obs0.reg_we), 32'h0);

        applyStimulus(32'h0020A423, 32'h0000_1010);
        chk("sw.imm", obs0.imm, 32'h8);
        chk("sw.mem_we", 32'(obs0.mem_we), 32'h1);
        chk("sw.mem_opw", 32'(obs0.mem_opw), 32'hF);
        chk("sw.reg_we", 32'(obs0.reg_we), 32'h0);

        applyStimulus(32'h00000013, 32'h0000_1014);
        chk("nop.reg_we", 32'(obs0.reg_we), 32'h0);
        chk("nop.illegal", 32'(obs0.illegal), 32'h0);
        tick();

        // Backpressure: A in main, B in skid, C held upstream.
        in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h100;
        tick();
        out_ready = 1'b0;
        in_instr = 32'h00200113; in_pc = 32'h104;
        tick();
        in_instr = 32'h00300193; in_pc = 32'h108;
        tick();
        chk("bp.in_ready_full", 32'(in_ready0), 32'h0);
        chk("bp.hold_a", obs0.pc, 32'h100);
        out_ready = 1'b1;
        tick();
        chk("bp.second_b", obs0.pc, 32'h104);
        chk("bp.ready_again", 32'(in_ready0), 32'h1);
        tick();
        in_valid = 1'b0;
        chk("bp.third_c", obs0.pc, 32'h108);
        chk("bp.third_rd", 32'(obs0.rd), 32'h3);
        tick();
        chk("bp.drained", 32'(out_valid0), 32'h0);

        // Flush with skid full and a same-cycle input.
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h200;
        tick();
        in_instr = 32'h00200113; in_pc = 32'h204;
        tick();
        in_instr = 32'h00300193; in_pc = 32'h208; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("flush.out_valid", 32'(out_valid0), 32'h0);
        chk("flush.in_ready", 32'(in_ready0), 32'h1);
        tick();
        chk("flush.dropped", 32'(out_valid0), 32'h0);

        for (int i = 0; i < 3000; i++) begin
            in_valid = ($urandom_range(0, 9) < 7);
            in_instr = randInstr();
            in_pc = $urandom() & 32'hFFFF_FFFC;
            out_ready = ($urandom_range(0, 9) < 7);
            flush = ($urandom_range(0, 31) == 0);
            tick();
        end
        flush = 1'b0;

        // Asynchronous reset while the stage holds instructions.
        in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc = 32'h300; out_ready = 1'b0;
        tick();
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst.out_valid", 32'(out_valid0), 32'h0);
        chk("arst.in_ready", 32'(in_ready0), 32'h0);
        chk("arst.pc", obs0.pc, 32'h0);
        chk("arst.imm", obs0.imm, 32'h0);
        chk("arst.rd", 32'(obs0.rd), 32'h0);
        chk("arst.reg_we", 32'(obs0.reg_we), 32'h0);
        in_valid = 1'b0;
        #10;
        rst_n = 1'b1;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered RV32I instruction-decode pipeline stage with valid/ready handshakes on both sides and a one-entry skid buffer.
- Sits between fetch and execute. Generalises the single-cycle control decoder with:
  - parametrised PC width;
  - optional M-extension decode;
  - illegal-instruction detection;
  - flush;
  - rd==x0 write suppression.

Parameters:
- PC_W, 32: width of in_pc/out_pc.
- SUPPORT_M, 0: 1 = decode MUL/DIV/REM (opcode 0110011, func7 0000001); 0 = flag them illegal.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  discard all held and incoming instructions this cycle
- in_valid  input  1  upstream instruction valid
- in_ready  output  1  stage can accept
- in_instr  input  32  instruction word
- in_pc  input  PC_W  instruction address
- out_valid  output  1  decoded bundle valid
- out_ready  input  1  downstream accepts
- out_pc  output  PC_W  registered in_pc
- out_rs1/out_rs2/out_rd  output  5 each  register fields [19:15]/[24:20]/[11:7]
- out_imm  output  32  sign-extended immediate (I/S/B/U/J by opcode; 0 for R/illegal)
- out_alu_ctr  output  5  ALU op
- out_alu_b_sel  output  1  0 = rs2, 1 = imm
- out_bxx  output  4  {is_branch, func3}
- out_jal / out_jalr  output  1 each  jump flags
- out_reg_we  output  1  register write enable
- out_mem_we  output  1  store enable
- out_mem2reg  output  3  writeback select
- out_mem_opr  output  3  load func3
- out_mem_opw  output  4  store byte mask
- out_illegal  output  1  instruction not supported

Behaviour:

Reset and handshake
- Reset (rst_n low, async): out_valid=0, skid empty, all out_* registers 0. in_ready is 0 while rst_n is low.
- in_ready = !skid_valid (registered source, no combinational path from out_ready).
- Accept when in_valid && in_ready.
- Main register load rules:
  - loads when (!out_valid || out_ready);
  - if occupied and not draining, an accepted instruction goes to skid;
  - on drain, skid moves to main; otherwise the accepted input moves to main.
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 instruction/cycle with out_ready held high.
- Order is preserved. A bundle is held stable while out_valid && !out_ready.
- flush: next edge out_valid=0 and skid empty. A same-cycle input is dropped. Flush beats every other event.

Opcode decode
- Supported opcodes: 0110111 LUI, 0010111 AUIPC, 1101111 JAL, 1100111 JALR, 1100011 B, 0000011 L, 0100011 S, 0010011 I-ALU, 0110011 R.

out_alu_ctr encoding
- Base ops, bit4=0: add 00000, sub 01000, sll 00001, slt 00010, sltu 00011, xor 00100, srl 00101, sra 01101, or 00110, and 00111.
- M ops, bit4=1: {2'b10, func3}.
- add is used by ADD, ADDI, JALR, loads, stores, LUI, AUIPC and JAL.
- Branches:
  - BEQ/BNE use sub;
  - BLT/BGE use slt;
  - BLTU/BGEU use sltu.
- ADDI never decodes as sub. The func7[5] check applies to R-type and to shift-immediates only.

Operand and control outputs
- out_alu_b_sel = 0 for R and B types, otherwise 1.
- out_bxx[3] = B-type; out_bxx[2:0] = func3.
- out_reg_we = 0 for any of: B, S, illegal, or rd==0. Otherwise 1.
- out_mem_we = 1 for S-type only.
- out_mem_opr = func3 for loads, else 0.
- out_mem_opw = store mask from func3: 000→0001, 001→0011, 010→1111; 0 for non-stores.
- out_mem2reg:
  - 000 ALU result;
  - 001 load data;
  - 010 for JAL/JALR;
  - 011 for LUI;
  - 100 for AUIPC.

Illegal instructions
- out_illegal=1 for:
  - unlisted opcode;
  - instr[1:0]!=11;
  - R-type func7 not in {0000000; 0100000 with func3 000/101; 0000001 with SUPPORT_M=1};
  - shift-imm with func7 not 0000000/0100000 (0100000 only with func3 101);
  - B func3 010/011;
  - load func3 011/110/111;
  - store func3 ≥ 011;
  - JALR func3 != 000.
- When illegal: reg_we, mem_we, jal, jalr and bxx[3] are forced 0, and the bundle is still delivered.

Test Plan:
- Reset sequence, then in 0x00500093 (addi x1,x0,5) with out_ready=1 → next cycle out_valid=1, imm=5, alu_ctr=00000, alu_b_sel=1, rd=1, reg_we=1, mem2reg=000.
- 0x402081B3 (sub x3,x1,x2) → alu_ctr=01000, alu_b_sel=0. Then 0xFE209EE3 (bne x1,x2,-4) → imm=0xFFFFFFFC, bxx=1001, alu_ctr=01000, reg_we=0.
- 0x022082B3 (mul): with SUPPORT_M=1 → alu_ctr=10000, illegal=0; with SUPPORT_M=0 → illegal=1, reg_we=0.
- 0x0020A423 (sw x2,8(x1)) → imm=8, mem_we=1, mem_opw=1111, reg_we=0. Then 0x00000013 with rd=0 → reg_we=0.
- Backpressure: stream A,B,C with out_ready=0 after A is accepted → B captured in skid, in_ready=0, C is held upstream. Raise out_ready → outputs A,B,C in order, with no loss or duplication.
- Flush with the skid full and in_valid=1 → next cycle out_valid=0 and in_ready=1. Then assert rst_n low mid-stream → all outputs 0 immediately.
